ped_crossing_ctrl: RTL and testbench
====================================

# ped_crossing_ctrl

Pedestrian-signal controller downstream of the traffic-light phase FSM, in the same `clk` domain. It latches a debounced pedestrian push-button request. On the next entry of the vehicle phase into RED, it runs a WALK interval and then a flashing-clearance countdown. It forces DONT_WALK whenever the vehicle phase is not RED.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles of the synchronised button before the debounced level changes.
- `WALK_CYCLES`, default 4: cycles of solid WALK.
- `CLEAR_CYCLES`, default 4: cycles of flashing clearance, max 15.
- `FLASH_HALF`, default 1: cycles per flash half-period.
- Constraint: 1 + WALK_CYCLES + CLEAR_CYCLES ≤ RED duration (10 cycles).

- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `phase`  in  2: vehicle phase, registered in the `clk` domain. RED=00, GREEN=01, YELLOW=10; 11 is illegal.
- `ped_btn`  in  1: raw, asynchronous push-button level.
- `walk`  out  1: WALK lamp.
- `dont_walk`  out  1: DONT_WALK lamp.
- `flash`  out  1: DONT_WALK flashing enable, valid during CLEAR.
- `countdown`  out  4: clearance cycles remaining; 0 outside CLEAR.
- `req_pending`  out  1: request latched and not yet served.
- `abort`  out  1: one-cycle pulse when WALK/CLEAR is cut short.
- `phase_err`  out  1: sticky flag; illegal phase seen since reset.

## Operation
- Button path:
  - 2-flop synchroniser feeds a debounce counter.
  - The debounced level follows the synced level after DEBOUNCE_CYCLES consecutive equal samples.
  - A rising edge of the debounced level sets `req_pending`.
- `phase_q` is a registered copy of `phase`. Define red_entry = (phase==RED) && (phase_q!=RED).
- FSM states: IDLE, WALK, CLEAR.
  - **IDLE:** dont_walk=1, walk=0. On red_entry with req_pending=1, go to WALK and clear req_pending.
  - **WALK:** walk=1, dont_walk=0 for WALK_CYCLES cycles, then go to CLEAR.
  - **CLEAR:** walk=0, dont_walk=1 for CLEAR_CYCLES cycles, then go to IDLE.
    - `countdown` shows CLEAR_CYCLES on the first CLEAR cycle and decrements to 1 on the last.
    - `flash` is 1 on the first CLEAR cycle and toggles every FLASH_HALF cycles.
- Abort: in WALK or CLEAR with phase != RED:
  - go to IDLE on the next edge;
  - walk=0, dont_walk=1, flash=0, countdown=0;
  - abort=1 for exactly one cycle;
  - req_pending stays as is.
- Illegal phase (11) is treated as not-RED (forces DONT_WALK / abort) and sets phase_err until reset.
- Button press during WALK or CLEAR latches req_pending, which is served at the next red_entry, never in the current RED.
- Press edge and red_entry on the same cycle with req_pending=0: the request latches, no WALK this RED.
- Repeated presses while req_pending=1 have no further effect.

## Timing
- Reset values:
  - walk=0, dont_walk=1, flash=0, countdown=0, req_pending=0, abort=0, phase_err=0.
  - FSM=IDLE, phase_q=RED, synchroniser and debounced level 0.
- phase_q resets to RED, so a RED present at reset release is not a red_entry.
- All outputs are registered.
- Request latency: from a ped_btn rise (held stable) to req_pending=1 is 2 + DEBOUNCE_CYCLES + 1 edges.
- WALK latency: walk rises on the edge at which red_entry is sampled. It is 1 on the cycle after `phase` first reads RED.
- Durations are exact: walk high for WALK_CYCLES cycles, then CLEAR for CLEAR_CYCLES cycles.
- Abort: outputs go safe on the first edge after phase leaves RED.
- Reset mid-WALK returns all outputs to reset values immediately (asynchronous) and drops any pending request.

## Structure
- Shared package `tl_pkg`:
  - phase encodings RED/GREEN/YELLOW, shared with the traffic-light FSM;
  - ped FSM state encoding IDLE/WALK/CLEAR.
- Sub-module `btn_debounce`, parameterised by DEBOUNCE_CYCLES: synchroniser, debounce counter and rising-edge pulse output.
- Top level: phase edge detect, request latch, FSM, interval counter, flash divider, phase_err flag.

## Test plan
- **Reset:** outputs equal reset values. Hold phase=RED for 20 cycles with no press → walk never rises.
- **Bounce:** toggle ped_btn 0/1 every cycle for 10 cycles, then hold 1 → exactly one req_pending rise, DEBOUNCE_CYCLES+3 edges after the hold starts.
- **Nominal:** press during GREEN, then phase YELLOW→RED.
  - walk=1 for 4 cycles starting the cycle after RED first appears.
  - Then 4 cycles with dont_walk=1, countdown 4,3,2,1 and flash 1,0,1,0.
  - Then IDLE with req_pending=0.
- **Press during WALK:** req_pending=1 through the rest of this RED. WALK occurs on the next RED entry only.
- **Abort:** drive phase to GREEN during the 2nd WALK cycle → next edge walk=0, dont_walk=1, abort pulses 1 cycle.
- **Illegal phase:** drive phase=11 once during CLEAR → abort pulse, phase_err=1 held until rst. Assert rst mid-WALK → outputs return to reset values without a clock.

Source files
------------

// File: rtl/tl_pkg.sv
// Encodings shared by the traffic-light phase FSM and the pedestrian crossing controller.
package tl_pkg;

  localparam logic [1:0] PH_RED     = 2'b00;
  localparam logic [1:0] PH_GREEN   = 2'b01;
  localparam logic [1:0] PH_YELLOW  = 2'b10;
  localparam logic [1:0] PH_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_CLEAR = 2'd2
  } ped_state_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/ped_crossing_ctrl_if.sv
// Signal bundle between the phase source / pedestrian lamps and ped_crossing_ctrl.
// No handshake: inputs are sampled every clk edge and every output is a registered level valid each cycle.
interface ped_crossing_ctrl_if;
  import tl_pkg::*;

  logic [1:0] phase;
  logic       ped_btn;
  logic       walk;
  logic       dont_walk;
  logic       flash;
  logic [3:0] countdown;
  logic       req_pending;
  logic       abort;
  logic       phase_err;
  ped_state_e state;

  modport master (
    output phase, ped_btn,
    input  walk, dont_walk, flash, countdown, req_pending, abort, phase_err, state
  );

  modport slave (
    input  phase, ped_btn,
    output walk, dont_walk, flash, countdown, req_pending, abort, phase_err, state
  );

endinterface

// File: rtl/ped_crossing_ctrl_btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter, registered rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter tracks how many consecutive samples disagreed with the current level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else                                   cnt_d   = cnt_q + 1'b1;
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian signal controller: latches a debounced request and runs WALK then flashing CLEAR
// on the next vehicle RED entry, forcing DONT_WALK (with an abort pulse) whenever RED is lost.
module ped_crossing_ctrl
  import tl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 4,
  parameter int CLEAR_CYCLES    = 4,
  parameter int FLASH_HALF      = 1
) (
  input logic                clk,
  input logic                rst,
  ped_crossing_ctrl_if.slave bus
);

  logic             btn_level, btn_rise;
  logic [1:0]       phase_q;
  logic             is_red, red_entry;
  ped_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             walk_q, walk_d;
  logic             dont_walk_q, dont_walk_d;
  logic             flash_q, flash_d;
  logic [3:0]       countdown_q, countdown_d;
  logic             req_q, req_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.ped_btn),
    .level   (btn_level),
    .rise    (btn_rise)
  );

  // The illegal encoding is deliberately not RED, so it behaves like losing the phase.
  assign is_red    = (bus.phase == PH_RED);
  assign red_entry = is_red && (phase_q != PH_RED);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    walk_d      = walk_q;
    dont_walk_d = dont_walk_q;
    flash_d     = flash_q;
    countdown_d = countdown_q;
    abort_d     = 1'b0;
    req_d       = req_q | btn_rise;
    err_d       = err_q | (bus.phase == PH_ILLEGAL);
    case (state_q)
      ST_IDLE: begin
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        flash_d     = 1'b0;
        countdown_d = 4'd0;
        if (red_entry && req_q) begin
          state_d     = ST_WALK;
          req_d       = 1'b0;
          walk_d      = 1'b1;
          dont_walk_d = 1'b0;
          cnt_d       = CNT_W'(WALK_CYCLES - 1);
        end
      end
      ST_WALK: begin
        if (!is_red) begin
          state_d     = ST_IDLE;
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          abort_d     = 1'b1;
        end else if (cnt_q == '0) begin
          state_d     = ST_CLEAR;
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          flash_d     = 1'b1;
          countdown_d = 4'(CLEAR_CYCLES);
          cnt_d       = CNT_W'(CLEAR_CYCLES - 1);
          fcnt_d      = CNT_W'(FLASH_HALF - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CLEAR: begin
        if (!is_red || cnt_q == '0) begin
          state_d     = ST_IDLE;
          flash_d     = 1'b0;
          countdown_d = 4'd0;
          abort_d     = !is_red;
        end else begin
          cnt_d       = cnt_q - 1'b1;
          countdown_d = countdown_q - 4'd1;
          if (fcnt_q == '0) begin
            flash_d = ~flash_q;
            fcnt_d  = CNT_W'(FLASH_HALF - 1);
          end else begin
            fcnt_d = fcnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PH_RED;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      flash_q     <= 1'b0;
      countdown_q <= 4'd0;
      req_q       <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      phase_q     <= bus.phase;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      flash_q     <= flash_d;
      countdown_q <= countdown_d;
      req_q       <= req_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
    end
  end

  assign bus.walk        = walk_q;
  assign bus.dont_walk   = dont_walk_q;
  assign bus.flash       = flash_q;
  assign bus.countdown   = countdown_q;
  assign bus.req_pending = req_q;
  assign bus.abort       = abort_q;
  assign bus.phase_err   = err_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: per-cycle expected lamp vectors queued by the stimulus,
// popped and compared by an independent monitor.
module tb_ped_crossing_ctrl;
  import tl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic probe = 1'b0;

  always #5 clk = ~clk;

  ped_crossing_ctrl_if bus ();

  ped_crossing_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .WALK_CYCLES     (4),
    .CLEAR_CYCLES    (4),
    .FLASH_HALF      (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Vector layout: {walk, dont_walk, flash, countdown[3:0], req_pending, abort, phase_err}
  logic [9:0] exp_q[$];
  string      name_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  wire [9:0] act = {bus.walk, bus.dont_walk, bus.flash, bus.countdown,
                    bus.req_pending, bus.abort, bus.phase_err};

  function automatic logic [9:0] ov(input bit w, input bit dw, input bit fl,
                                    input logic [3:0] cd, input bit rq,
                                    input bit ab, input bit er);
    return {w, dw, fl, cd, rq, ab, er};
  endfunction

  // Monitor: compares the oldest expectation against the DUT outputs away from the clock edge.
  always @(negedge clk or posedge probe) begin : monitor
    logic [9:0] e;
    string      nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_chk++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %b required %b (t=%0t)", nm, act, e, $time);
    end
  end

  task automatic expect_vec(input logic [9:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Drive inputs for one cycle, then queue the outputs expected after the edge that samples them.
  task automatic tick(input logic [1:0] ph, input logic b, input logic [9:0] e, input string nm);
    bus.phase   = ph;
    bus.ped_btn = b;
    @(posedge clk);
    #1;
    expect_vec(e, nm);
  endtask

  // Hold the button for 8 cycles in GREEN, then release for 7; request appears after edge 7.
  task automatic press_in_green(input bit er, input string nm);
    for (int k = 1; k <= 8; k++)
      tick(PH_GREEN, 1'b1, ov(0, 1, 0, 4'd0, (k >= 7), 0, er), nm);
    for (int k = 0; k < 7; k++)
      tick(PH_GREEN, 1'b0, ov(0, 1, 0, 4'd0, 1, 0, er), {nm, "_rel"});
  endtask

  task automatic walk_clear(input bit rq_late, input string nm);
    for (int k = 1; k <= 4; k++)
      tick(PH_RED, 1'b0, ov(1, 0, 0, 4'd0, 0, 0, 0), {nm, "_walk"});
    for (int k = 0; k < 4; k++)
      tick(PH_RED, 1'b0, ov(0, 1, ~k[0], 4'(4 - k), rq_late, 0, 0), {nm, "_clear"});
  endtask

  initial begin
    bus.phase   = PH_RED;
    bus.ped_btn = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_vec(ov(0, 1, 0, 4'd0, 0, 0, 0), "reset_values");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // RED present at reset release is not an entry; no press means no WALK.
    for (int k = 0; k < 20; k++)
      tick(PH_RED, 1'b0, ov(0, 1, 0, 4'd0, 0, 0, 0), "red_no_press");

    // Bounce then hold: single request, D+3 edges after the hold begins.
    for (int k = 0; k < 10; k++)
      tick(PH_GREEN, (k % 2 == 0), ov(0, 1, 0, 4'd0, 0, 0, 0), "bounce");
    for (int k = 1; k <= 10; k++)
      tick(PH_GREEN, 1'b1, ov(0, 1, 0, 4'd0, (k >= 7), 0, 0), "bounce_hold");
    for (int k = 0; k < 8; k++)
      tick(PH_GREEN, 1'b0, ov(0, 1, 0, 4'd0, 1, 0, 0), "bounce_release");

    // Nominal service on YELLOW -> RED.
    for (int k = 0; k < 2; k++)
      tick(PH_YELLOW, 1'b0, ov(0, 1, 0, 4'd0, 1, 0, 0), "nom_yellow");
    walk_clear(1'b0, "nom");
    for (int k = 0; k < 2; k++)
      tick(PH_RED, 1'b0, ov(0, 1, 0, 4'd0, 0, 0, 0), "nom_idle");

    // Press during WALK: latched, served only on the following RED entry.
    press_in_green(1'b0, "pw_press");
    tick(PH_YELLOW, 1'b0, ov(0, 1, 0, 4'd0, 1, 0, 0), "pw_yellow");
    tick(PH_RED, 1'b0, ov(1, 0, 0, 4'd0, 0, 0, 0), "pw_walk1");
    for (int k = 2; k <= 4; k++)
      tick(PH_RED, 1'b1, ov(1, 0, 0, 4'd0, 0, 0, 0), "pw_walk");
    for (int k = 5; k <= 8; k++)
      tick(PH_RED, (k <= 7), ov(0, 1, (k % 2 == 1), 4'(9 - k), (k >= 8), 0, 0), "pw_clear");
    for (int k = 0; k < 2; k++)
      tick(PH_RED, 1'b0, ov(0, 1, 0, 4'd0, 1, 0, 0), "pw_same_red");
    for (int k = 0; k < 2; k++)
      tick(PH_GREEN, 1'b0, ov(0, 1, 0, 4'd0, 1, 0, 0), "pw_green");
    tick(PH_YELLOW, 1'b0, ov(0, 1, 0, 4'd0, 1, 0, 0), "pw_yellow2");

    // Served at the next entry, then abort in the 2nd WALK cycle.
    tick(PH_RED, 1'b0, ov(1, 0, 0, 4'd0, 0, 0, 0), "ab_walk1");
    tick(PH_RED, 1'b0, ov(1, 0, 0, 4'd0, 0, 0, 0), "ab_walk2");
    tick(PH_GREEN, 1'b0, ov(0, 1, 0, 4'd0, 0, 1, 0), "ab_pulse");
    for (int k = 0; k < 3; k++)
      tick(PH_GREEN, 1'b0, ov(0, 1, 0, 4'd0, 0, 0, 0), "ab_after");

    // Illegal phase during CLEAR: abort pulse and sticky phase_err.
    press_in_green(1'b0, "il_press");
    tick(PH_YELLOW, 1'b0, ov(0, 1, 0, 4'd0, 1, 0, 0), "il_yellow");
    for (int k = 1; k <= 4; k++)
      tick(PH_RED, 1'b0, ov(1, 0, 0, 4'd0, 0, 0, 0), "il_walk");
    tick(PH_RED, 1'b0, ov(0, 1, 1, 4'd4, 0, 0, 0), "il_clear1");
    tick(PH_ILLEGAL, 1'b0, ov(0, 1, 0, 4'd0, 0, 1, 1), "il_abort");
    for (int k = 0; k < 4; k++)
      tick(PH_RED, 1'b0, ov(0, 1, 0, 4'd0, 0, 0, 1), "il_sticky");

    // Asynchronous reset in the middle of WALK.
    press_in_green(1'b1, "rs_press");
    tick(PH_YELLOW, 1'b0, ov(0, 1, 0, 4'd0, 1, 0, 1), "rs_yellow");
    tick(PH_RED, 1'b0, ov(1, 0, 0, 4'd0, 0, 0, 1), "rs_walk1");
    tick(PH_RED, 1'b0, ov(1, 0, 0, 4'd0, 0, 0, 1), "rs_walk2");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    expect_vec(ov(0, 1, 0, 4'd0, 0, 0, 0), "rs_async");
    probe = 1'b1;
    #1;
    probe = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++)
      tick(PH_RED, 1'b0, ov(0, 1, 0, 4'd0, 0, 0, 0), "rs_after");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
